// File: rtl/commit_ctrl_if.sv
// Shared commit types and the scoreboard-to-commit port bundle.
// Ports 0..NR-1 carry head entries oldest-first with per-port retire/write info.
package commit_pkg;

  typedef enum logic [3:0] {
    NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR, FPU, FPU_VEC
  } fu_t;

  typedef enum logic [4:0] {
    ADD, SUB, LD, SD, FENCE, FENCE_I, SFENCE_VMA,
    CSR_RW, CSR_RS, CSR_RC, AMO_ADD, AMO_SWAP, LR, SC,
    FADD, FMUL, FLD, FMV_X_D
  } fu_op;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic        ack;
    logic [63:0] result;
  } amo_resp_t;

  typedef struct packed {
    fu_t         fu;
    fu_op        op;
    logic [4:0]  rd;
    logic [63:0] result;
    logic        valid;
    exception_t  ex;
  } scoreboard_entry_t;

  function automatic logic is_amo(input fu_op op);
    return op inside {AMO_ADD, AMO_SWAP, LR, SC};
  endfunction

  function automatic logic is_rd_fpr(input fu_op op);
    return op inside {FADD, FMUL, FLD};
  endfunction

  function automatic logic is_serial_op(input fu_op op);
    return op inside {FENCE, FENCE_I, SFENCE_VMA};
  endfunction

  function automatic logic fu_multi_ok(input fu_t fu);
    return fu inside {ALU, LOAD, CTRL_FLOW, MULT, FPU, FPU_VEC, STORE};
  endfunction

endpackage

interface commit_ctrl_if #(
  parameter int unsigned NR = 2
);
  import commit_pkg::*;

  scoreboard_entry_t commit_instr_i [NR];
  logic [NR-1:0]     commit_ack_o;
  logic [4:0]        waddr_o [NR];
  logic [63:0]       wdata_o [NR];
  logic [NR-1:0]     we_gpr_o;
  logic [NR-1:0]     we_fpr_o;

  modport master (
    output commit_instr_i,
    input  commit_ack_o, waddr_o, wdata_o, we_gpr_o, we_fpr_o
  );

  modport slave (
    input  commit_instr_i,
    output commit_ack_o, waddr_o, wdata_o, we_gpr_o, we_fpr_o
  );
endinterface

// File: rtl/commit_ctrl.sv
// In-order N-port commit controller with serialising-op FSM and instret.
// Port 0 alone may carry exceptions, CSR ops, fences and AMOs.
module commit_ctrl
  import commit_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               halt_i,
  input  logic               single_step_i,
  input  logic               flush_dcache_i,
  commit_ctrl_if.slave       cp,
  output logic               commit_lsu_o,
  input  logic               commit_lsu_ready_i,
  input  logic               no_st_pending_i,
  input  amo_resp_t          amo_resp_i,
  output logic               amo_valid_commit_o,
  output logic               commit_csr_o,
  output fu_op               csr_op_o,
  output logic [63:0]        csr_wdata_o,
  input  logic [63:0]        csr_rdata_i,
  input  exception_t         csr_exception_i,
  output logic               csr_write_fflags_o,
  output exception_t         exception_o,
  output logic               fence_o,
  output logic               fence_i_o,
  output logic               sfence_vma_o,
  output logic               flush_commit_o,
  output logic [63:0]        instret_o
);

  localparam int unsigned N = NR_COMMIT_PORTS;

  typedef enum logic [1:0] {IDLE, DRAIN, AMO_WAIT} state_t;
  typedef enum logic [1:0] {K_FENCE, K_FENCE_I, K_SFENCE} kind_t;

  state_t            state_q;
  kind_t             kind_q;
  kind_t             kind_d;
  logic [63:0]       instret_q;
  scoreboard_entry_t ci0;
  logic              p0_serial;
  logic              p0_amo;
  logic              drain_done;
  logic              amo_done;
  logic [N-1:0]      ack;
  logic [N-1:0]      we_gpr;
  logic [N-1:0]      we_fpr;
  logic [4:0]        waddr [N];
  logic [63:0]       wdata [N];
  logic [4:0]        fflags;
  logic              fflags_v;
  logic [3:0]        cnt;

  assign ci0 = cp.commit_instr_i[0];

  assign p0_serial = is_serial_op(ci0.op)
                   || (flush_dcache_i && ci0.fu != STORE);
  assign p0_amo    = is_amo(ci0.op);

  assign drain_done = state_q == DRAIN && ci0.valid
                    && !halt_i && no_st_pending_i;
  assign amo_done   = state_q == AMO_WAIT && ci0.valid
                    && !halt_i && amo_resp_i.ack;

  // flush_dcache shares the fence.i drain path
  always_comb begin
    kind_d = K_FENCE_I;
    unique case (1'b1)
      ci0.op == SFENCE_VMA:
        kind_d = K_SFENCE;
      ci0.op == FENCE && !flush_dcache_i:
        kind_d = K_FENCE;
      default:
        kind_d = K_FENCE_I;
    endcase
  end

  always_comb begin
    exception_o = '0;
    if (ci0.valid) begin
      if (csr_exception_i.valid) begin
        exception_o      = csr_exception_i;
        exception_o.tval = ci0.ex.tval;
      end
      if (ci0.ex.valid) exception_o = ci0.ex;
    end
    if (halt_i) exception_o.valid = 1'b0;
  end

  assign commit_csr_o = state_q == IDLE && ci0.valid
                      && !halt_i && ci0.fu == CSR
                      && !ci0.ex.valid && !p0_serial;
  assign csr_op_o     = commit_csr_o ? ci0.op : ADD;
  assign csr_wdata_o  = commit_csr_o ? ci0.result
                                     : {59'd0, fflags};
  assign csr_write_fflags_o = fflags_v;

  always_comb begin : ack_chain
    logic chain;
    logic ok;
    logic ex_k;
    logic ex_seen;
    logic st_used;
    ack      = '0;
    we_gpr   = '0;
    we_fpr   = '0;
    fflags   = '0;
    fflags_v = 1'b0;
    cnt      = '0;
    chain    = 1'b1;
    ok       = 1'b0;
    ex_k     = 1'b0;
    ex_seen  = 1'b0;
    st_used  = 1'b0;
    for (int k = 0; k < N; k++) begin
      waddr[k] = cp.commit_instr_i[k].rd;
      wdata[k] = cp.commit_instr_i[k].result;
      ok = chain && cp.commit_instr_i[k].valid && !halt_i;
      if (k == 0) begin
        ex_k    = exception_o.valid;
        ex_seen = ex_k;
        unique case (state_q)
          IDLE:
            if (!ex_k && (p0_serial || p0_amo)) ok = 1'b0;
          DRAIN:    ok = drain_done;
          AMO_WAIT: ok = amo_done;
          default:  ok = 1'b0;
        endcase
      end else begin
        ex_k    = cp.commit_instr_i[k].ex.valid;
        ex_seen = ex_seen | ex_k;
        if (state_q != IDLE || ci0.fu == CSR || ex_seen
            || single_step_i
            || !fu_multi_ok(cp.commit_instr_i[k].fu)
            || is_serial_op(cp.commit_instr_i[k].op)
            || is_amo(cp.commit_instr_i[k].op))
          ok = 1'b0;
      end
      if (ok && state_q == IDLE && !ex_k
          && cp.commit_instr_i[k].fu == STORE) begin
        if (st_used || !commit_lsu_ready_i) ok = 1'b0;
        else st_used = 1'b1;
      end
      ack[k] = ok;
      chain  = ok;
      if (ok && !ex_k) begin
        cnt = cnt + 4'd1;
        if (is_rd_fpr(cp.commit_instr_i[k].op)) we_fpr[k] = 1'b1;
        else we_gpr[k] = 1'b1;
        if (cp.commit_instr_i[k].fu inside {FPU, FPU_VEC}) begin
          fflags_v = 1'b1;
          fflags   = fflags | cp.commit_instr_i[k].ex.cause[4:0];
        end
      end
    end
    if (amo_done) wdata[0] = amo_resp_i.result;
    else if (commit_csr_o) wdata[0] = csr_rdata_i;
    commit_lsu_o = st_used;
  end

  assign cp.commit_ack_o = ack;
  assign cp.we_gpr_o     = we_gpr;
  assign cp.we_fpr_o     = we_fpr;
  assign cp.waddr_o      = waddr;
  assign cp.wdata_o      = wdata;

  assign amo_valid_commit_o = state_q == AMO_WAIT;
  assign flush_commit_o     = amo_done;
  assign fence_o      = drain_done && kind_q == K_FENCE;
  assign fence_i_o    = drain_done && kind_q == K_FENCE_I;
  assign sfence_vma_o = drain_done && kind_q == K_SFENCE;
  assign instret_o    = instret_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      kind_q    <= K_FENCE;
      instret_q <= '0;
    end else begin
      instret_q <= instret_q + 64'(cnt);
      unique case (state_q)
        IDLE:
          if (ci0.valid && !halt_i && !exception_o.valid) begin
            if (p0_serial) begin
              state_q <= DRAIN;
              kind_q  <= kind_d;
            end else if (p0_amo) begin
              state_q <= AMO_WAIT;
            end
          end
        DRAIN:
          if (!ci0.valid || drain_done) state_q <= IDLE;
        AMO_WAIT:
          if (!ci0.valid || amo_done) state_q <= IDLE;
        default:
          state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_commit_ctrl.sv
// Directed bench for commit_ctrl at four commit ports.
// Each scenario drives vectors and checks hand-computed outputs inline.
module tb_commit_ctrl;
  import commit_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        halt_i, single_step_i, flush_dcache_i;
  logic        commit_lsu_o, commit_lsu_ready_i, no_st_pending_i;
  amo_resp_t   amo_resp_i;
  logic        amo_valid_commit_o, commit_csr_o;
  fu_op        csr_op_o;
  logic [63:0] csr_wdata_o, csr_rdata_i;
  exception_t  csr_exception_i, exception_o;
  logic        csr_write_fflags_o;
  logic        fence_o, fence_i_o, sfence_vma_o, flush_commit_o;
  logic [63:0] instret_o;
  logic [63:0] exp_inst;
  int          n_chk = 0;
  int          n_fail = 0;

  commit_ctrl_if #(.NR(4)) cif ();

  commit_ctrl #(.NR_COMMIT_PORTS(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .halt_i(halt_i),
    .single_step_i(single_step_i), .flush_dcache_i(flush_dcache_i),
    .cp(cif.slave), .commit_lsu_o(commit_lsu_o),
    .commit_lsu_ready_i(commit_lsu_ready_i),
    .no_st_pending_i(no_st_pending_i), .amo_resp_i(amo_resp_i),
    .amo_valid_commit_o(amo_valid_commit_o),
    .commit_csr_o(commit_csr_o), .csr_op_o(csr_op_o),
    .csr_wdata_o(csr_wdata_o), .csr_rdata_i(csr_rdata_i),
    .csr_exception_i(csr_exception_i),
    .csr_write_fflags_o(csr_write_fflags_o),
    .exception_o(exception_o), .fence_o(fence_o),
    .fence_i_o(fence_i_o), .sfence_vma_o(sfence_vma_o),
    .flush_commit_o(flush_commit_o), .instret_o(instret_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic scoreboard_entry_t mk(
    input fu_t f, input fu_op o, input logic [4:0] rd,
    input logic [63:0] r);
    scoreboard_entry_t e;
    e = '0;
    e.fu = f; e.op = o; e.rd = rd; e.result = r; e.valid = 1'b1;
    return e;
  endfunction

  task automatic clr();
    for (int k = 0; k < 4; k++) cif.commit_instr_i[k] = '0;
    halt_i = 0; single_step_i = 0; flush_dcache_i = 0;
    commit_lsu_ready_i = 1; no_st_pending_i = 1;
    amo_resp_i = '0; csr_rdata_i = '0; csr_exception_i = '0;
  endtask

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic chk_inst(input string nm);
    n_chk++;
    if (instret_o !== exp_inst) begin
      n_fail++;
      $display("FAIL %s: instret got %0d want %0d", nm, instret_o, exp_inst);
    end
  endtask

  task automatic test_reset();
    rst_ni = 0; clr(); exp_inst = 0;
    step(); step();
    n_chk++; if (instret_o !== 64'd0) begin n_fail++; $display("FAIL rst_instret: got %0d want 0", instret_o); end
    n_chk++; if (cif.commit_ack_o !== 4'b0000) begin n_fail++; $display("FAIL rst_ack: got %b want 0000", cif.commit_ack_o); end
    n_chk++; if (csr_op_o !== ADD) begin n_fail++; $display("FAIL rst_csr_op: got %0d want ADD", csr_op_o); end
    n_chk++; if ({fence_o, fence_i_o, sfence_vma_o, flush_commit_o, amo_valid_commit_o} !== 5'b0) begin
      n_fail++; $display("FAIL rst_pulses: got %b want 00000", {fence_o, fence_i_o, sfence_vma_o, flush_commit_o, amo_valid_commit_o}); end
    rst_ni = 1; step();
  endtask

  task automatic test_alu4();
    for (int k = 0; k < 4; k++) cif.commit_instr_i[k] = mk(ALU, ADD, 5'(k + 1), 64'(k * 16));
    #1;
    n_chk++; if (cif.commit_ack_o !== 4'b1111) begin n_fail++; $display("FAIL alu4_ack: got %b want 1111", cif.commit_ack_o); end
    n_chk++; if (cif.we_gpr_o !== 4'b1111) begin n_fail++; $display("FAIL alu4_we: got %b want 1111", cif.we_gpr_o); end
    n_chk++; if (cif.waddr_o[3] !== 5'd4) begin n_fail++; $display("FAIL alu4_waddr: got %0d want 4", cif.waddr_o[3]); end
    n_chk++; if (cif.wdata_o[2] !== 64'd32) begin n_fail++; $display("FAIL alu4_wdata: got %0d want 32", cif.wdata_o[2]); end
    step(); clr(); exp_inst += 4; chk_inst("alu4_instret");
  endtask

  task automatic test_stores();
    cif.commit_instr_i[0] = mk(ALU, ADD, 1, 0);
    cif.commit_instr_i[1] = mk(STORE, SD, 0, 0);
    cif.commit_instr_i[2] = mk(ALU, ADD, 2, 0);
    cif.commit_instr_i[3] = mk(STORE, SD, 0, 0);
    #1;
    n_chk++; if (cif.commit_ack_o !== 4'b0111) begin n_fail++; $display("FAIL st_1_3_ack: got %b want 0111", cif.commit_ack_o); end
    n_chk++; if (commit_lsu_o !== 1'b1) begin n_fail++; $display("FAIL st_1_3_lsu: got %b want 1", commit_lsu_o); end
    step(); clr();
    cif.commit_instr_i[0] = mk(ALU, ADD, 1, 0);
    cif.commit_instr_i[1] = mk(STORE, SD, 0, 0);
    cif.commit_instr_i[2] = mk(STORE, SD, 0, 0);
    cif.commit_instr_i[3] = mk(ALU, ADD, 3, 0);
    #1;
    n_chk++; if (cif.commit_ack_o !== 4'b0011) begin n_fail++; $display("FAIL st_1_2_ack: got %b want 0011", cif.commit_ack_o); end
    n_chk++; if (commit_lsu_o !== 1'b1) begin n_fail++; $display("FAIL st_1_2_lsu: got %b want 1", commit_lsu_o); end
    step(); clr();
    cif.commit_instr_i[0] = mk(ALU, ADD, 1, 0);
    cif.commit_instr_i[1] = mk(STORE, SD, 0, 0);
    commit_lsu_ready_i = 0;
    #1;
    n_chk++; if (cif.commit_ack_o !== 4'b0001) begin n_fail++; $display("FAIL st_nrdy_ack: got %b want 0001", cif.commit_ack_o); end
    n_chk++; if (commit_lsu_o !== 1'b0) begin n_fail++; $display("FAIL st_nrdy_lsu: got %b want 0", commit_lsu_o); end
    step(); clr(); exp_inst += 6; chk_inst("st_instret");
  endtask

  task automatic test_fence();
    cif.commit_instr_i[0] = mk(CSR, FENCE, 0, 0);
    cif.commit_instr_i[1] = mk(ALU, ADD, 1, 0);
    no_st_pending_i = 0;
    for (int c = 1; c <= 3; c++) begin
      #1;
      n_chk++; if (cif.commit_ack_o !== 4'b0000 || fence_o !== 1'b0) begin
        n_fail++; $display("FAIL fence_wait%0d: ack %b fence %b want 0000 0", c, cif.commit_ack_o, fence_o); end
      step();
    end
    no_st_pending_i = 1; #1;
    n_chk++; if (cif.commit_ack_o !== 4'b0001) begin n_fail++; $display("FAIL fence_ack: got %b want 0001", cif.commit_ack_o); end
    n_chk++; if ({fence_o, fence_i_o, sfence_vma_o} !== 3'b100) begin n_fail++; $display("FAIL fence_pulse: got %b want 100", {fence_o, fence_i_o, sfence_vma_o}); end
    step(); clr(); exp_inst += 1;
    cif.commit_instr_i[0] = mk(ALU, ADD, 1, 0);
    cif.commit_instr_i[1] = mk(ALU, ADD, 2, 0);
    #1;
    n_chk++; if (fence_o !== 1'b0) begin n_fail++; $display("FAIL fence_once: got %b want 0", fence_o); end
    n_chk++; if (cif.commit_ack_o !== 4'b0011) begin n_fail++; $display("FAIL fence_idle: got %b want 0011", cif.commit_ack_o); end
    step(); clr(); exp_inst += 2; chk_inst("fence_instret");
  endtask

  task automatic test_amo();
    cif.commit_instr_i[0] = mk(STORE, AMO_ADD, 5, 0);
    #1;
    n_chk++; if (cif.commit_ack_o !== 4'b0000 || amo_valid_commit_o !== 1'b0) begin
      n_fail++; $display("FAIL amo_idle: ack %b avc %b want 0000 0", cif.commit_ack_o, amo_valid_commit_o); end
    step();
    for (int c = 1; c <= 3; c++) begin
      #1;
      n_chk++; if (amo_valid_commit_o !== 1'b1 || cif.commit_ack_o !== 4'b0000 || flush_commit_o !== 1'b0) begin
        n_fail++; $display("FAIL amo_wait%0d: avc %b ack %b flush %b want 1 0000 0", c, amo_valid_commit_o, cif.commit_ack_o, flush_commit_o); end
      step();
    end
    halt_i = 1; amo_resp_i.ack = 1; amo_resp_i.result = 64'hDEAD; #1;
    n_chk++; if (cif.commit_ack_o !== 4'b0000 || flush_commit_o !== 1'b0) begin
      n_fail++; $display("FAIL amo_halt: ack %b flush %b want 0000 0", cif.commit_ack_o, flush_commit_o); end
    step();
    halt_i = 0; #1;
    n_chk++; if (cif.commit_ack_o !== 4'b0001) begin n_fail++; $display("FAIL amo_ack: got %b want 0001", cif.commit_ack_o); end
    n_chk++; if (cif.we_gpr_o[0] !== 1'b1 || cif.wdata_o[0] !== 64'hDEAD) begin
      n_fail++; $display("FAIL amo_wr: we %b data %h want 1 dead", cif.we_gpr_o[0], cif.wdata_o[0]); end
    n_chk++; if (flush_commit_o !== 1'b1) begin n_fail++; $display("FAIL amo_flush: got %b want 1", flush_commit_o); end
    step(); clr(); exp_inst += 1; #1;
    n_chk++; if (flush_commit_o !== 1'b0 || amo_valid_commit_o !== 1'b0) begin
      n_fail++; $display("FAIL amo_done: flush %b avc %b want 0 0", flush_commit_o, amo_valid_commit_o); end
    chk_inst("amo_instret");
  endtask

  task automatic test_exception();
    scoreboard_entry_t e;
    cif.commit_instr_i[0] = mk(ALU, ADD, 1, 0);
    e = mk(ALU, ADD, 2, 0); e.ex.valid = 1; cif.commit_instr_i[1] = e;
    cif.commit_instr_i[2] = mk(ALU, ADD, 3, 0);
    #1;
    n_chk++; if (cif.commit_ack_o !== 4'b0001) begin n_fail++; $display("FAIL ex_p1_ack: got %b want 0001", cif.commit_ack_o); end
    n_chk++; if (exception_o.valid !== 1'b0) begin n_fail++; $display("FAIL ex_p1_valid: got %b want 0", exception_o.valid); end
    step(); clr(); exp_inst += 1;
    e = mk(ALU, ADD, 1, 0); e.ex.valid = 1; e.ex.cause = 2; e.ex.tval = 64'h40;
    cif.commit_instr_i[0] = e;
    cif.commit_instr_i[1] = mk(ALU, ADD, 2, 0);
    #1;
    n_chk++; if (cif.commit_ack_o !== 4'b0001 || cif.we_gpr_o !== 4'b0000) begin
      n_fail++; $display("FAIL ex_p0_ack: ack %b we %b want 0001 0000", cif.commit_ack_o, cif.we_gpr_o); end
    n_chk++; if (exception_o.valid !== 1'b1 || exception_o.cause !== 64'd2 || exception_o.tval !== 64'h40) begin
      n_fail++; $display("FAIL ex_p0_exc: v %b cause %0d tval %h want 1 2 40", exception_o.valid, exception_o.cause, exception_o.tval); end
    step(); clr();
    e = mk(CSR, CSR_RW, 4, 0); e.ex.tval = 64'h1234; cif.commit_instr_i[0] = e;
    csr_exception_i.valid = 1; csr_exception_i.cause = 7; csr_exception_i.tval = 64'h99;
    #1;
    n_chk++; if (exception_o.valid !== 1'b1 || exception_o.cause !== 64'd7 || exception_o.tval !== 64'h1234) begin
      n_fail++; $display("FAIL ex_csr: v %b cause %0d tval %h want 1 7 1234", exception_o.valid, exception_o.cause, exception_o.tval); end
    n_chk++; if (cif.commit_ack_o !== 4'b0001 || cif.we_gpr_o !== 4'b0000) begin
      n_fail++; $display("FAIL ex_csr_ack: ack %b we %b want 0001 0000", cif.commit_ack_o, cif.we_gpr_o); end
    step(); clr(); chk_inst("ex_instret");
  endtask

  task automatic test_single_halt();
    scoreboard_entry_t e;
    single_step_i = 1;
    cif.commit_instr_i[0] = mk(ALU, ADD, 1, 0);
    cif.commit_instr_i[1] = mk(ALU, ADD, 2, 0);
    #1;
    n_chk++; if (cif.commit_ack_o !== 4'b0001) begin n_fail++; $display("FAIL sstep_ack: got %b want 0001", cif.commit_ack_o); end
    step(); clr(); exp_inst += 1;
    halt_i = 1;
    e = mk(ALU, ADD, 1, 0); e.ex.valid = 1; cif.commit_instr_i[0] = e;
    cif.commit_instr_i[1] = mk(ALU, ADD, 2, 0);
    #1;
    n_chk++; if (cif.commit_ack_o !== 4'b0000) begin n_fail++; $display("FAIL halt_ack: got %b want 0000", cif.commit_ack_o); end
    n_chk++; if (exception_o.valid !== 1'b0) begin n_fail++; $display("FAIL halt_exc: got %b want 0", exception_o.valid); end
    step(); clr(); chk_inst("sh_instret");
  endtask

  task automatic test_csr_fflags();
    scoreboard_entry_t e;
    cif.commit_instr_i[0] = mk(CSR, CSR_RS, 7, 64'h55);
    cif.commit_instr_i[1] = mk(ALU, ADD, 2, 0);
    csr_rdata_i = 64'hAB;
    #1;
    n_chk++; if (cif.commit_ack_o !== 4'b0001 || commit_csr_o !== 1'b1) begin
      n_fail++; $display("FAIL csr_ack: ack %b csr %b want 0001 1", cif.commit_ack_o, commit_csr_o); end
    n_chk++; if (csr_op_o !== CSR_RS || csr_wdata_o !== 64'h55 || cif.wdata_o[0] !== 64'hAB) begin
      n_fail++; $display("FAIL csr_data: op %0d wd %h rd %h want CSR_RS 55 ab", csr_op_o, csr_wdata_o, cif.wdata_o[0]); end
    step(); clr(); exp_inst += 1;
    e = mk(FPU, FADD, 1, 0); e.ex.cause = 1; cif.commit_instr_i[0] = e;
    e = mk(FPU_VEC, FMUL, 2, 0); e.ex.cause = 4; cif.commit_instr_i[1] = e;
    e = mk(FPU, FMV_X_D, 3, 0); e.ex.cause = 16; cif.commit_instr_i[2] = e;
    #1;
    n_chk++; if (cif.commit_ack_o !== 4'b0111 || cif.we_fpr_o !== 4'b0011 || cif.we_gpr_o !== 4'b0100) begin
      n_fail++; $display("FAIL ff_we: ack %b fpr %b gpr %b want 0111 0011 0100", cif.commit_ack_o, cif.we_fpr_o, cif.we_gpr_o); end
    n_chk++; if (csr_write_fflags_o !== 1'b1 || csr_wdata_o !== 64'h15) begin
      n_fail++; $display("FAIL ff_data: en %b wd %h want 1 15", csr_write_fflags_o, csr_wdata_o); end
    step(); clr(); exp_inst += 3; chk_inst("csr_instret");
  endtask

  task automatic test_flush_sfence();
    flush_dcache_i = 1;
    cif.commit_instr_i[0] = mk(ALU, ADD, 1, 0);
    #1;
    n_chk++; if (cif.commit_ack_o !== 4'b0000) begin n_fail++; $display("FAIL fd_idle: got %b want 0000", cif.commit_ack_o); end
    step(); flush_dcache_i = 0; #1;
    n_chk++; if (cif.commit_ack_o !== 4'b0001 || {fence_o, fence_i_o, sfence_vma_o} !== 3'b010) begin
      n_fail++; $display("FAIL fd_drain: ack %b pulses %b want 0001 010", cif.commit_ack_o, {fence_o, fence_i_o, sfence_vma_o}); end
    step(); clr(); exp_inst += 1;
    cif.commit_instr_i[0] = mk(CSR, SFENCE_VMA, 0, 0);
    step(); #1;
    n_chk++; if (cif.commit_ack_o !== 4'b0001 || {fence_o, fence_i_o, sfence_vma_o} !== 3'b001) begin
      n_fail++; $display("FAIL sfence: ack %b pulses %b want 0001 001", cif.commit_ack_o, {fence_o, fence_i_o, sfence_vma_o}); end
    step(); clr(); exp_inst += 1; chk_inst("fd_instret");
  endtask

  task automatic test_flush_drop();
    cif.commit_instr_i[0] = mk(CSR, FENCE, 0, 0);
    no_st_pending_i = 0;
    step();
    cif.commit_instr_i[0] = '0; #1;
    n_chk++; if (cif.commit_ack_o !== 4'b0000 || fence_o !== 1'b0) begin
      n_fail++; $display("FAIL drop_cyc: ack %b fence %b want 0000 0", cif.commit_ack_o, fence_o); end
    step();
    no_st_pending_i = 1;
    cif.commit_instr_i[0] = mk(ALU, ADD, 1, 0);
    cif.commit_instr_i[1] = mk(ALU, ADD, 2, 0);
    #1;
    n_chk++; if (cif.commit_ack_o !== 4'b0011 || fence_o !== 1'b0) begin
      n_fail++; $display("FAIL drop_idle: ack %b fence %b want 0011 0", cif.commit_ack_o, fence_o); end
    step(); clr(); exp_inst += 2; chk_inst("drop_instret");
  endtask

  task automatic test_reset_drain();
    cif.commit_instr_i[0] = mk(CSR, FENCE, 0, 0);
    no_st_pending_i = 0;
    step();
    rst_ni = 0; no_st_pending_i = 1; #1;
    exp_inst = 0;
    n_chk++; if (fence_o !== 1'b0 || cif.commit_ack_o !== 4'b0000) begin
      n_fail++; $display("FAIL rstd_pulse: fence %b ack %b want 0 0000", fence_o, cif.commit_ack_o); end
    chk_inst("rstd_instret");
    rst_ni = 1; #1;
    n_chk++; if (fence_o !== 1'b0 || cif.commit_ack_o !== 4'b0000) begin
      n_fail++; $display("FAIL rstd_idle: fence %b ack %b want 0 0000", fence_o, cif.commit_ack_o); end
    clr(); step();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) cif.commit_instr_i[k] = mk(ALU, ADD, 5'(k + 1), 0);
    #1;
    n_chk++; if (cif.commit_ack_o !== 4'b0111) begin n_fail++; $display("FAIL b2b_0: got %b want 0111", cif.commit_ack_o); end
    step();
    for (int k = 0; k < 4; k++) cif.commit_instr_i[k] = mk(k == 2 ? MULT : ALU, ADD, 5'(k + 8), 0);
    #1;
    n_chk++; if (cif.commit_ack_o !== 4'b1111) begin n_fail++; $display("FAIL b2b_1: got %b want 1111", cif.commit_ack_o); end
    step(); clr(); exp_inst += 7; chk_inst("b2b_instret");
  endtask

  initial begin
    test_reset();
    test_alu4();
    test_stores();
    test_fence();
    test_amo();
    test_exception();
    test_single_halt();
    test_csr_fflags();
    test_flush_sfence();
    test_flush_drop();
    test_reset_drain();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
